// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
package sram_pkg;

    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_ADDR_WIDTH = 8;

    // Controller phases: address setup, strobe pulse, strobe release, host response.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_RESP
    } sram_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one request at a time,
// SETUP -> ACCESS (ACCESS_CYCLES) -> HOLD -> RESP, valid/ready on both host sides.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH    = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH    = SRAM_ADDR_WIDTH,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_chip_enable,
    output logic                  sram_write_enable,
    output logic                  sram_output_enable,
    output logic                  sram_reset
);

    // Counter only has to reach ACCESS_CYCLES-1.
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    sram_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  active;
    logic                  drv_en;

    // State and request registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: latch on accept, count down the strobe, sample read data on its last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = ST_SETUP;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    rdata_d = '0;      // writes report zero data
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    if (!write_q) rdata_d = sram_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so a reset releases them immediately.
    // The bus is only driven on writes, and OE only falls on reads, so they never overlap.
    assign active             = (state_q == ST_SETUP) || (state_q == ST_ACCESS) || (state_q == ST_HOLD);
    assign drv_en             = active && write_q;
    assign sram_chip_enable   = !active;
    assign sram_write_enable  = !((state_q == ST_ACCESS) && write_q);
    assign sram_output_enable = !((state_q == ST_ACCESS) && !write_q);
    assign sram_data          = drv_en ? wdata_q : {DATA_WIDTH{1'bz}};
    assign sram_address       = addr_q;
    assign req_ready          = (state_q == ST_IDLE) && reset_n;
    assign rsp_valid          = (state_q == ST_RESP);
    assign rsp_rdata          = rdata_q;
    assign sram_reset         = ~reset_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench: two controllers (ACCESS_CYCLES 2 and 1) each on a 256x16 SRAM model,
// compared against a word-array model of memory contents and the phase timing.
module tb_sram_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    req_valid;
    logic          req_write;
    logic          rsp_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          req_ready0, rsp_valid0, ce0, we0, oe0, srst0;
    logic          req_ready1, rsp_valid1, ce1, we1, oe1, srst1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] saddr0, saddr1;
    wire  [DW-1:0] bus0, bus1;

    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] model_mem [2][256];

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rdata0),
        .sram_address(saddr0), .sram_data(bus0),
        .sram_chip_enable(ce0), .sram_write_enable(we0), .sram_output_enable(oe0),
        .sram_reset(srst0)
    );

    sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rdata1),
        .sram_address(saddr1), .sram_data(bus1),
        .sram_chip_enable(ce1), .sram_write_enable(we1), .sram_output_enable(oe1),
        .sram_reset(srst1)
    );

    // Power-on / reset contents of the SRAM.
    function automatic logic [DW-1:0] init_word(input int a);
        case (a)
            50:      return 16'd115;
            124:     return 16'h3779;
            242:     return 16'd120;
            default: return DW'(a * 257) ^ 16'h5a5a;
        endcase
    endfunction

    // SRAM models: drive on CE&OE low, write on clock while CE&WE low, initialise on sram_reset.
    assign bus0 = (!ce0 && !oe0) ? mem0[saddr0] : {DW{1'bz}};
    assign bus1 = (!ce1 && !oe1) ? mem1[saddr1] : {DW{1'bz}};

    always @(posedge clk) begin
        if (srst0) begin
            for (int i = 0; i < 256; i++) mem0[i] <= init_word(i);
        end else if (!ce0 && !we0) begin
            mem0[saddr0] <= bus0;
        end
    end

    always @(posedge clk) begin
        if (srst1) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
        end else if (!ce1 && !we1) begin
            mem1[saddr1] <= bus1;
        end
    end

    // Selected-controller view used by the checks.
    logic          m_ready, m_rv, m_ce, m_we, m_oe, m_srst, m_drv;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_addr;

    always_comb begin
        if (sel == 0) begin
            m_ready = req_ready0; m_rv = rsp_valid0; m_ce = ce0; m_we = we0; m_oe = oe0;
            m_srst = srst0; m_drv = dut0.drv_en; m_rdata = rdata0; m_addr = saddr0;
        end else begin
            m_ready = req_ready1; m_rv = rsp_valid1; m_ce = ce1; m_we = we1; m_oe = oe1;
            m_srst = srst1; m_drv = dut1.drv_en; m_rdata = rdata1; m_addr = saddr1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic init_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) model_mem[s][i] = init_word(i);
    endtask

    // One transaction on the selected controller, starting at a negedge in IDLE.
    // stall = number of extra cycles rsp_ready is held low once the response is up.
    task automatic op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int stall, output int we_low, output int oe_low);
        int k;
        logic [DW-1:0] exp;
        we_low = 0;
        oe_low = 0;
        chk("ready_idle", 32'(m_ready), 1);
        req_valid = (sel == 0) ? 2'b01 : 2'b10;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = (stall == 0);
        @(posedge clk);
        #1 req_valid = 2'b00;
        if (wr) begin
            model_mem[sel][a] = d;
            exp = '0;
        end else begin
            exp = model_mem[sel][a];
        end
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (m_rv) break;
            if (!m_we) we_low++;
            if (!m_oe) oe_low++;
            if (!m_we || !m_oe) chk("we_oe_excl", 32'(!m_we && !m_oe), 0);
            if (!m_oe) chk("drv_while_oe", 32'(m_drv), 0);
            chk("busy_ready", 32'(m_ready), 0);
        end
        chk("rsp_latency", 32'(k), 32'(3 + ((sel == 0) ? 2 : 1)));
        chk("rsp_rdata", 32'(m_rdata), 32'(exp));
        chk("resp_strobes", 32'({m_ce, m_we, m_oe}), 32'b111);
        chk("resp_bus", 32'(m_drv), 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(m_rv), 1);
            chk("stall_rdata", 32'(m_rdata), 32'(exp));
            chk("stall_ready", 32'(m_ready), 0);
            chk("stall_strobes", 32'({m_ce, m_we, m_oe}), 32'b111);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(m_ready), 1);
        chk("idle_valid", 32'(m_rv), 0);
        chk("idle_strobes", 32'({m_ce, m_we, m_oe}), 32'b111);
        chk("idle_bus", 32'(m_drv), 0);
        chk("addr_hold", 32'(m_addr), 32'(a));
    endtask

    initial begin
        int wl, ol;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_strobes", 32'({m_ce, m_we, m_oe}), 32'b111);
        chk("rst_bus", 32'(m_drv), 0);
        chk("rst_valid", 32'(m_rv), 0);
        chk("rst_ready", 32'(m_ready), 0);
        chk("rst_sram_reset", 32'(m_srst), 1);
        chk("rst_addr", 32'(m_addr), 0);
        chk("rst_rdata", 32'(m_rdata), 0);
        reset_n = 1'b1;
        init_model();
        #1 chk("run_sram_reset", 32'(m_srst), 0);

        // Reads of preloaded words, first one accepted on the first edge out of reset
        op(0, 8'd50, '0, 0, wl, ol);
        chk("rd50_value", 32'(m_rdata), 115);
        op(0, 8'd124, '0, 0, wl, ol);
        op(0, 8'd242, '0, 0, wl, ol);

        // Write then read back, with strobe widths
        op(1, 8'h10, 16'h00ab, 0, wl, ol);
        chk("wr_we_cycles", 32'(wl), 2);
        chk("wr_oe_cycles", 32'(ol), 0);
        op(0, 8'h10, '0, 0, wl, ol);
        chk("rd_oe_cycles", 32'(ol), 2);
        chk("rd_we_cycles", 32'(wl), 0);
        chk("rd10_value", 32'(m_rdata), 16'h00ab);

        // Response back-pressure
        op(0, 8'($urandom_range(0, 255)), '0, 4, wl, ol);

        // Reset during read ACCESS
        req_valid = 2'b01; req_write = 1'b0; req_addr = 8'd77; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("mid_oe_low", 32'(m_oe), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({m_ce, m_we, m_oe}), 32'b111);
        chk("mid_rst_valid", 32'(m_rv), 0);
        chk("mid_rst_bus", 32'(m_drv), 0);
        chk("mid_rst_rdata", 32'(m_rdata), 0);
        chk("mid_rst_sram_reset", 32'(m_srst), 1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        init_model();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(m_rv), 0);
        end
        op(0, 8'd77, '0, 0, wl, ol);

        // Random traffic on a small window so reads hit earlier writes
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom_range(0, 15));
            d = 16'($urandom);
            op(1'($urandom_range(0, 1)), a, d, int'($urandom_range(0, 2)), wl, ol);
        end

        // Back-to-back alternating write/read at ACCESS_CYCLES = 1
        sel = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            d = 16'($urandom);
            op(1, a, d, 0, wl, ol);
            chk("b2b_we_cycles", 32'(wl), 1);
            op(0, a, '0, 0, wl, ol);
            chk("b2b_readback", 32'(m_rdata), 32'(d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the address width.
REQ-003 Parameter ACCESS_CYCLES, default 2, min 1, SHALL set the number of cycles the WE/OE strobe is held low.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req_valid  input  1  SHALL qualify a host request.
REQ-007 req_ready  output  1  SHALL indicate that a request can be accepted.
REQ-008 req_write  input  1  SHALL select the operation: 1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH  SHALL carry the request address.
REQ-010 req_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-011 rsp_valid  output  1  SHALL flag completion (read data, or write acknowledge).
REQ-012 rsp_ready  input  1  SHALL be the host's acceptance of a response.
REQ-013 rsp_rdata  output  DATA_WIDTH  SHALL carry the read data; it SHALL be 0 for writes.
REQ-014 sram_address  output  ADDR_WIDTH  SHALL drive the SRAM address.
REQ-015 sram_data  inout  DATA_WIDTH  SHALL be the SRAM bidirectional data bus.
REQ-016 sram_chip_enable, sram_write_enable, sram_output_enable  output  1 each  SHALL be the active-low SRAM strobes.
REQ-017 sram_reset  output  1  SHALL drive the SRAM content-initialise input, active-high.

Function
REQ-018 The controller SHALL implement the FSM states IDLE, SETUP, ACCESS, HOLD and RESP.
REQ-019 A request SHALL be accepted on the edge where req_valid && req_ready; req_ready SHALL be 1 only in IDLE.
- On acceptance the controller SHALL latch addr, wdata and write, then go to SETUP.
REQ-020 SETUP SHALL last 1 cycle:
- chip_enable = 0, write_enable = 1, output_enable = 1.
- Address driven.
- On a write, sram_data SHALL be driven with the latched wdata; otherwise sram_data SHALL be Z.
REQ-021 ACCESS SHALL last ACCESS_CYCLES cycles, tracked by a down-counter:
- Write: write_enable = 0, output_enable = 1, data driven.
- Read: output_enable = 0, write_enable = 1, data Z; sram_data SHALL be captured into rsp_rdata on the last ACCESS cycle.
REQ-022 HOLD SHALL last 1 cycle:
- write_enable = 1, output_enable = 1, chip_enable = 0, address held.
- On a write, data SHALL stay driven; otherwise data SHALL be Z.
REQ-023 RESP: rsp_valid = 1, chip_enable = 1, and the bus SHALL be Z.
- The controller SHALL stay in RESP until rsp_ready, then return to IDLE.
- rsp_rdata SHALL stay stable while rsp_valid is high.
REQ-024 rsp_valid SHALL first assert 3+ACCESS_CYCLES cycles after the accepting edge (5 at the default).
REQ-025 The controller SHALL never drive sram_data while sram_output_enable = 0, and write_enable and output_enable SHALL never be low together.
REQ-026 In IDLE all strobes SHALL be 1, sram_data SHALL be Z, and sram_address SHALL hold its last value.
REQ-027 A new req_valid arriving during an operation SHALL be ignored until IDLE; the host SHALL hold it (valid/ready rule).
- Back-to-back operation SHALL be possible: accepting in IDLE on the cycle after the RESP handshake is allowed.
REQ-028 sram_reset SHALL equal ~reset_n, combinationally.

Reset
REQ-029 With reset_n = 0 the following SHALL hold asynchronously:
- State = IDLE.
- All strobes = 1.
- sram_data = Z.
- rsp_valid = 0, req_ready = 0, rsp_rdata = 0, sram_address = 0, counter = 0.
REQ-030 A reset asserted mid-operation SHALL abort the operation, with no response.
- The first accept SHALL be possible on the first clk edge after reset_n rises.

Structure
REQ-031 A shared package sram_pkg SHALL hold the FSM state enum and the DATA_WIDTH/ADDR_WIDTH defaults.
REQ-032 The block SHALL be a single module with no sub-modules; tristate via a continuous assignment gated by an internal drive-enable.

Verification
REQ-033 The bench SHALL instantiate sram_ctrl with sram (16/8/256) and cover these scenarios:
- Reset with reset_n = 0 -> strobes 1, sram_data Z, rsp_valid 0, sram_reset 1.
- Read addr 50 after reset -> rsp_rdata = 115 at cycle 5; read addr 124 -> 0x3779; read addr 242 -> 120.
- Write 0x00AB to addr 0x10, then read 0x10 -> 0x00AB.
  - In this scenario the bench SHALL check that WE is low for exactly 2 cycles and OE stays 1 during the write.
- Read with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata held, req_ready 0, no new strobes.
- reset_n pulsed low during read ACCESS -> OE rises immediately, no rsp_valid, next request completes normally.
- 8 back-to-back alternating write/read requests at ACCESS_CYCLES = 1 -> each read returns the prior write, with no cycle where the bus is driven while OE = 0.
